magia_tb_banked_mem: RTL and testbench



---
 rtl/magia_tb_banked_mem.sv | 100 ++++++++++
 tb/tb_magia_tb_banked_mem.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/magia_tb_banked_mem.sv
// magia_tb_banked_mem: word-interleaved banked memory, one request channel per tile,
// per-bank round-robin arbitration, fixed-latency responses, per-tile conflict counters.
// Ports: clk_i/rst_ni clock and async active-low reset; req_i/gnt_o per-tile handshake;
// addr_i/we_i/be_i/wdata_i request payload; rvalid_o/rdata_o response after RESP_LAT cycles;
// clr_stats_i clears conflict_cnt_o (cycles a tile requested but was not granted).
module magia_tb_banked_mem #(
  parameter int N_TILES      = 2,
  parameter int N_MEM_BANKS  = 32,
  parameter int N_WORDS_BANK = 4096,
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 32,
  parameter int RESP_LAT     = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [N_TILES-1:0]    req_i,
  output logic [N_TILES-1:0]    gnt_o,
  input  logic [ADDR_W-1:0]     addr_i [N_TILES],
  input  logic [N_TILES-1:0]    we_i,
  input  logic [DATA_W/8-1:0]   be_i [N_TILES],
  input  logic [DATA_W-1:0]     wdata_i [N_TILES],
  output logic [N_TILES-1:0]    rvalid_o,
  output logic [DATA_W-1:0]     rdata_o [N_TILES],
  input  logic                  clr_stats_i,
  output logic [31:0]           conflict_cnt_o [N_TILES]
);
  localparam int BE_W   = DATA_W / 8;
  localparam int OFF_W  = $clog2(BE_W);
  localparam int BANK_W = $clog2(N_MEM_BANKS);
  localparam int WORD_W = $clog2(N_WORDS_BANK);
  localparam int TID_W  = N_TILES > 1 ? $clog2(N_TILES) : 1;
  logic [BANK_W-1:0]    bank [N_TILES];
  logic [WORD_W-1:0]    word [N_TILES];
  logic [DATA_W-1:0]    rd_word [N_TILES];
  logic [N_TILES-1:0]   addr_unused;
  logic [DATA_W-1:0]    mem [N_MEM_BANKS][N_WORDS_BANK];
  logic [TID_W-1:0]     ptr [N_MEM_BANKS];
  logic [TID_W-1:0]     win [N_MEM_BANKS];
  logic [N_MEM_BANKS-1:0] hit;
  logic [N_TILES-1:0]   gnt;
  logic [N_TILES-1:0]   vpipe [RESP_LAT];
  logic [DATA_W-1:0]    dpipe [RESP_LAT][N_TILES];
  int                   idx;
  // Offset bits and bits above the array size are ignored, so addresses alias.
  for (genvar t = 0; t < N_TILES; t++) begin : g_dec
    assign bank[t]        = addr_i[t][OFF_W +: BANK_W];
    assign word[t]        = addr_i[t][OFF_W + BANK_W +: WORD_W];
    assign rd_word[t]     = mem[bank[t]][word[t]];
    assign addr_unused[t] = ^addr_i[t];
  end
  // Each bank scans tiles starting just after its last winner; first requester wins.
  always_comb begin
    gnt = '0;
    hit = '0;
    idx = 0;
    for (int b = 0; b < N_MEM_BANKS; b++) begin
      win[b] = '0;
      for (int k = 1; k <= N_TILES; k++) begin
        idx = (int'(ptr[b]) + k) % N_TILES;
        if (!hit[b] && req_i[idx] && bank[idx] == BANK_W'(b)) begin
          hit[b]   = 1'b1;
          win[b]   = TID_W'(idx);
          gnt[idx] = 1'b1;
        end
      end
    end
  end
  assign gnt_o    = rst_ni ? gnt : '0;
  assign rvalid_o = vpipe[RESP_LAT-1];
  assign rdata_o  = dpipe[RESP_LAT-1];
  // Array is never reset; only the granted tile of each bank may write it.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < N_MEM_BANKS; b++)
      if (rst_ni && hit[b] && we_i[win[b]])
        for (int i = 0; i < BE_W; i++)
          if (be_i[win[b]][i]) mem[b][word[win[b]]][8*i +: 8] <= wdata_i[win[b]][8*i +: 8];
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int b = 0; b < N_MEM_BANKS; b++) ptr[b] <= TID_W'(N_TILES - 1);
      for (int s = 0; s < RESP_LAT; s++) begin
        vpipe[s] <= '0;
        for (int t = 0; t < N_TILES; t++) dpipe[s][t] <= '0;
      end
      for (int t = 0; t < N_TILES; t++) conflict_cnt_o[t] <= '0;
    end else begin
      for (int b = 0; b < N_MEM_BANKS; b++) if (hit[b]) ptr[b] <= win[b];
      vpipe[0] <= gnt;
      for (int t = 0; t < N_TILES; t++) dpipe[0][t] <= (gnt[t] && !we_i[t]) ? rd_word[t] : '0;
      for (int s = 1; s < RESP_LAT; s++) begin
        vpipe[s] <= vpipe[s-1];
        dpipe[s] <= dpipe[s-1];
      end
      for (int t = 0; t < N_TILES; t++)
        conflict_cnt_o[t] <= clr_stats_i ? '0 :
                             (req_i[t] && !gnt[t] && !(&conflict_cnt_o[t])) ? conflict_cnt_o[t] + 32'd1 :
                             conflict_cnt_o[t];
    end
  end
endmodule

// File: tb/tb_magia_tb_banked_mem.sv
// tb_magia_tb_banked_mem: randomized and directed checks of the banked memory against a behavioural model.
module tb_magia_tb_banked_mem;
  localparam int NT = 3, NB = 4, NW = 16, DW = 32, AW = 16, LAT = 2;
  localparam int TW = NB * NW;
  logic clk = 1'b0, rst_n = 1'b1, clr = 1'b0;
  logic [NT-1:0] req = '0, we = '0, gnt, rvalid;
  logic [AW-1:0] addr [NT];
  logic [3:0] be [NT];
  logic [DW-1:0] wdata [NT], rdata [NT];
  logic [31:0] cnt [NT];
  typedef struct { int due; logic [31:0] data; } resp_t;
  resp_t rq [NT][$];
  logic [31:0] mref [TW];
  int ptr_m [NB];
  logic [31:0] cnt_m [NT];
  int cyc = 0, vectors = 0, miscompares = 0;
  magia_tb_banked_mem #(.N_TILES(NT), .N_MEM_BANKS(NB), .N_WORDS_BANK(NW), .DATA_W(DW),
                        .ADDR_W(AW), .RESP_LAT(LAT)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt), .addr_i(addr), .we_i(we),
    .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid), .rdata_o(rdata),
    .clr_stats_i(clr), .conflict_cnt_o(cnt));
  always #5 clk = ~clk;
  function automatic int bank_of(logic [AW-1:0] a);
    return int'(a >> 2) % NB;
  endfunction
  function automatic int widx(logic [AW-1:0] a);
    return int'(a >> 2) % TW;
  endfunction
  task automatic idle();
    req = '0; we = '0; clr = 1'b0;
    for (int t = 0; t < NT; t++) begin addr[t] = '0; be[t] = '0; wdata[t] = '0; end
  endtask
  task automatic set_req(int t, bit w, logic [AW-1:0] a, logic [3:0] b, logic [31:0] d);
    req[t] = 1'b1; we[t] = w; addr[t] = a; be[t] = b; wdata[t] = d;
  endtask
  task automatic tick();
    logic [NT-1:0] eg;
    int best, bd, d;
    resp_t r;
    #2;
    eg = '0;
    for (int b = 0; b < NB; b++) begin
      best = -1; bd = NT;
      for (int t = 0; t < NT; t++)
        if (req[t] && bank_of(addr[t]) == b) begin
          d = (t - ptr_m[b] - 1 + 2 * NT) % NT;
          if (d < bd) begin bd = d; best = t; end
        end
      if (best >= 0) begin eg[best] = 1'b1; ptr_m[b] = best; end
    end
    vectors++;
    if (gnt !== eg) begin
      miscompares++;
      $display("FAIL gnt cyc=%0d got=%b exp=%b", cyc, gnt, eg);
    end
    for (int t = 0; t < NT; t++)
      if (eg[t]) begin
        r.due = cyc + LAT;
        r.data = we[t] ? 32'h0 : mref[widx(addr[t])];
        rq[t].push_back(r);
      end
    for (int t = 0; t < NT; t++)
      if (eg[t] && we[t])
        for (int i = 0; i < 4; i++)
          if (be[t][i]) mref[widx(addr[t])][8*i +: 8] = wdata[t][8*i +: 8];
    for (int t = 0; t < NT; t++)
      cnt_m[t] = clr ? 32'h0 : (req[t] && !eg[t] && cnt_m[t] != 32'hFFFF_FFFF) ? cnt_m[t] + 1 : cnt_m[t];
    @(posedge clk);
    #1;
    cyc++;
    for (int t = 0; t < NT; t++) begin
      bit ev;
      ev = rq[t].size() > 0 && rq[t][0].due == cyc;
      vectors++;
      if (rvalid[t] !== ev) begin
        miscompares++;
        $display("FAIL rvalid t%0d cyc=%0d got=%b exp=%b", t, cyc, rvalid[t], ev);
      end
      if (ev) begin
        r = rq[t].pop_front();
        vectors++;
        if (rdata[t] !== r.data) begin
          miscompares++;
          $display("FAIL rdata t%0d cyc=%0d got=%h exp=%h", t, cyc, rdata[t], r.data);
        end
      end
      vectors++;
      if (cnt[t] !== cnt_m[t]) begin
        miscompares++;
        $display("FAIL conflict_cnt t%0d cyc=%0d got=%0d exp=%0d", t, cyc, cnt[t], cnt_m[t]);
      end
    end
  endtask
  task automatic drain();
    idle();
    repeat (LAT + 1) tick();
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    vectors++;
    if (gnt !== '0) begin miscompares++; $display("FAIL reset_gnt got=%b exp=0", gnt); end
    for (int t = 0; t < NT; t++) begin
      vectors++;
      if (rvalid[t] !== 1'b0 || rdata[t] !== '0 || cnt[t] !== '0) begin
        miscompares++;
        $display("FAIL reset_out t%0d rvalid=%b rdata=%h cnt=%0d exp 0/0/0", t, rvalid[t], rdata[t], cnt[t]);
      end
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int b = 0; b < NB; b++) ptr_m[b] = NT - 1;
    for (int t = 0; t < NT; t++) begin cnt_m[t] = '0; rq[t].delete(); end
  endtask
  task automatic test_prefill();
    for (int w = 0; w < TW; w++) begin
      idle();
      set_req(w % NT, 1'b1, AW'(w * 4), 4'hF, $urandom);
      tick();
    end
    drain();
  endtask
  task automatic test_single();
    idle(); set_req(0, 1'b1, 16'h0100, 4'hF, 32'hDEADBEEF); tick();
    idle(); set_req(0, 1'b0, 16'h0100, 4'h0, 32'h0); tick();
    idle(); tick();
    vectors++;
    if (rvalid[0] !== 1'b0 || rdata[0] !== 32'hDEADBEEF) begin end
    if (rdata[0] !== 32'hDEADBEEF) begin miscompares++; $display("FAIL single_read got=%h exp=deadbeef", rdata[0]); end
    drain();
  endtask
  task automatic test_byte_enable();
    idle(); set_req(1, 1'b1, 16'h0020, 4'hF, 32'h11223344); tick();
    idle(); set_req(1, 1'b1, 16'h0020, 4'b0101, 32'hAABBCCDD); tick();
    idle(); set_req(1, 1'b0, 16'h0020, 4'h0, 32'h0); tick();
    idle(); tick();
    vectors++;
    if (rdata[1] !== 32'h11BB33DD) begin miscompares++; $display("FAIL byte_enable got=%h exp=11bb33dd", rdata[1]); end
    drain();
  endtask
  task automatic test_conflict();
    logic [31:0] c0 [NT];
    for (int t = 0; t < NT; t++) c0[t] = cnt[t];
    for (int k = 0; k < 6; k++) begin
      idle();
      for (int t = 0; t < NT; t++) set_req(t, 1'b0, AW'(12 + 16 * t), 4'h0, 32'h0);
      tick();
    end
    drain();
    for (int t = 0; t < NT; t++) begin
      vectors++;
      if (cnt[t] - c0[t] !== 32'd4) begin
        miscompares++;
        $display("FAIL conflict_delta t%0d got=%0d exp=4", t, cnt[t] - c0[t]);
      end
    end
  endtask
  task automatic test_distinct();
    for (int k = 0; k < 4; k++) begin
      idle();
      for (int t = 0; t < NT; t++) set_req(t, k[0], AW'(4 * t), 4'hF, $urandom);
      tick();
    end
    drain();
  endtask
  task automatic test_alias();
    idle(); set_req(2, 1'b1, 16'h0004, 4'hF, 32'hCAFEF00D); tick();
    idle(); set_req(2, 1'b0, AW'(TW * 4 + 4), 4'h0, 32'h0); tick();
    idle(); set_req(2, 1'b0, 16'hFF04, 4'h0, 32'h0); tick();
    vectors++;
    if (rdata[2] !== 32'hCAFEF00D) begin miscompares++; $display("FAIL alias got=%h exp=cafef00d", rdata[2]); end
    drain();
  endtask
  task automatic test_clear();
    for (int k = 0; k < 4; k++) begin
      idle();
      for (int t = 0; t < NT; t++) set_req(t, 1'b0, AW'(16 * t), 4'h0, 32'h0);
      clr = (k == 2);
      tick();
    end
    drain();
  endtask
  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      idle();
      for (int t = 0; t < NT; t++)
        if ($urandom_range(0, 3) != 0) set_req(t, 1'($urandom), AW'($urandom), 4'($urandom), $urandom);
      clr = ($urandom_range(0, 19) == 0);
      tick();
    end
    drain();
  endtask
  task automatic test_reset_midflight();
    idle();
    for (int t = 0; t < NT; t++) set_req(t, 1'b0, AW'(4 * t), 4'h0, 32'h0);
    tick();
    for (int t = 0; t < NT; t++) set_req(t, 1'b0, AW'(16 * t), 4'h0, 32'h0);
    test_reset();
    idle();
    repeat (LAT + 2) tick();
    for (int t = 0; t < NT; t++) set_req(t, 1'b0, AW'(16 * t), 4'h0, 32'h0);
    #2;
    vectors++;
    if (gnt !== 3'b001) begin miscompares++; $display("FAIL restart_prio got=%b exp=001", gnt); end
    tick();
    drain();
  endtask
  initial begin
    idle();
    #1;
    test_reset();
    test_prefill();
    test_single();
    test_byte_enable();
    test_conflict();
    test_distinct();
    test_alias();
    test_clear();
    test_random();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
